// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and constants: broadcast/buffer record layout and result-port numbering.
package cdb_arbiter_pkg;

    localparam int XLEN        = 32;
    localparam int ROB_TAG_LEN = 5;

    typedef struct packed {
        logic                   valid;
        logic [ROB_TAG_LEN-1:0] rob_tag;
        logic [XLEN-1:0]        value;
    } CDB_DATA;

    // Same layout as the broadcast; one of these sits in each per-port holding buffer.
    typedef struct packed {
        logic                   valid;
        logic [ROB_TAG_LEN-1:0] rob_tag;
        logic [XLEN-1:0]        value;
    } CDB_REQ;

    localparam int CDB_NUM_REQ = 4;
    localparam int CDB_ALU     = 0;
    localparam int CDB_MULT    = 1;
    localparam int CDB_LD      = 2;
    localparam int CDB_BR      = 3;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-port and broadcast bundle between the functional units and the CDB arbiter.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = CDB_NUM_REQ
) ();
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ-1:0][XLEN-1:0]        req_value;
    logic [NUM_REQ-1:0][ROB_TAG_LEN-1:0] req_rob_tag;
    logic [NUM_REQ-1:0]                  req_ready;
    logic [NUM_REQ-1:0]                  squash_mask;
    CDB_DATA                             cdb_data;
    logic [PTR_W-1:0]                    grant_idx;
    logic [NUM_REQ-1:0]                  buf_occupied;

    // The arbiter owns the bus side; producers and the flush logic drive the other.
    modport master (
        input  req_valid, req_value, req_rob_tag, squash_mask,
        output req_ready, cdb_data, grant_idx, buf_occupied
    );

    modport slave (
        output req_valid, req_value, req_rob_tag, squash_mask,
        input  req_ready, cdb_data, grant_idx, buf_occupied
    );
endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of eligible at or after rr_ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any_grant
);
    int               sum;
    logic [PTR_W-1:0] sel;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        sum       = 0;
        sel       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Modular add that also works when NUM_REQ is not a power of two.
            sum = int'(rr_ptr) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            sel = PTR_W'(sum);
            if (!any_grant && eligible[sel]) begin
                grant[sel] = 1'b1;
                grant_idx  = sel;
                any_grant  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one holding buffer per result port, round-robin grant into
// a registered broadcast, per-port squash of wrong-path results.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = CDB_NUM_REQ
) (
    input  logic          clock,
    input  logic          reset,
    cdb_arbiter_if.master bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    CDB_REQ             buf_reg [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] ready;
    logic [NUM_REQ-1:0] accept;
    logic [PTR_W-1:0]   pick_idx;
    logic               any_grant;
    logic [PTR_W-1:0]   rr_ptr_reg;
    logic [PTR_W-1:0]   grant_idx_reg;
    CDB_DATA            cdb_data_reg;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr_reg),
        .grant     (grant),
        .grant_idx (pick_idx),
        .any_grant (any_grant)
    );

    // Ready looks only at buffer state and squash, never at req_valid.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign eligible[gi]         = buf_reg[gi].valid & ~bus.squash_mask[gi];
            assign ready[gi]            = ~bus.squash_mask[gi] & (~buf_reg[gi].valid | grant[gi]);
            assign accept[gi]           = bus.req_valid[gi] & ready[gi];
            assign bus.buf_occupied[gi] = buf_reg[gi].valid;
        end
    endgenerate

    assign bus.req_ready = ready;
    assign bus.cdb_data  = cdb_data_reg;
    assign bus.grant_idx = grant_idx_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                buf_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    // Tag 0 was never allocated in the ROB: ack it but keep the slot empty.
                    buf_reg[i].valid   <= (bus.req_rob_tag[i] != '0);
                    buf_reg[i].rob_tag <= bus.req_rob_tag[i];
                    buf_reg[i].value   <= bus.req_value[i];
                end else if (grant[i] || bus.squash_mask[i]) begin
                    buf_reg[i].valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cdb_data_reg  <= '0;
            grant_idx_reg <= '0;
            rr_ptr_reg    <= '0;
        end else if (any_grant) begin
            cdb_data_reg.valid   <= 1'b1;
            cdb_data_reg.rob_tag <= buf_reg[pick_idx].rob_tag;
            cdb_data_reg.value   <= buf_reg[pick_idx].value;
            grant_idx_reg        <= pick_idx;
            rr_ptr_reg           <= (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
        end else begin
            cdb_data_reg.valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized bench for cdb_arbiter against a queue-free behavioural model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N = 4;

    logic clock;
    logic reset;

    cdb_arbiter_if #(.NUM_REQ(N)) bus ();

    cdb_arbiter #(.NUM_REQ(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Stimulus for the next cycle
    logic                   drv_rst;
    logic [N-1:0]           drv_valid;
    logic [N-1:0]           drv_sq;
    logic [ROB_TAG_LEN-1:0] drv_tag   [N];
    logic [XLEN-1:0]        drv_value [N];

    // Behavioural model state
    bit                     m_full  [N];
    logic [ROB_TAG_LEN-1:0] m_tag   [N];
    logic [XLEN-1:0]        m_value [N];
    int                     m_ptr;
    CDB_DATA                m_cdb;
    int                     m_gidx;

    task automatic idle_drive();
        drv_rst   = 1'b0;
        drv_valid = '0;
        drv_sq    = '0;
        for (int i = 0; i < N; i++) begin
            drv_tag[i]   = '0;
            drv_value[i] = '0;
        end
    endtask

    task automatic offer(input int port, input int tag, input logic [XLEN-1:0] value);
        drv_valid[port] = 1'b1;
        drv_tag[port]   = ROB_TAG_LEN'(tag);
        drv_value[port] = value;
    endtask

    // One clock: drive, check ready before the edge, advance model, check outputs after.
    task automatic step(input string tag);
        int           g;
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_occ;
        reset           = drv_rst;
        bus.req_valid   = drv_valid;
        bus.squash_mask = drv_sq;
        for (int i = 0; i < N; i++) begin
            bus.req_rob_tag[i] = drv_tag[i];
            bus.req_value[i]   = drv_value[i];
        end
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && m_full[idx] && !drv_sq[idx]) g = idx;
        end
        for (int i = 0; i < N; i++) begin
            exp_ready[i] = !drv_sq[i] && (!m_full[i] || g == i);
        end
        if (!drv_rst) begin
            n_checks++;
            assert (bus.req_ready === exp_ready) n_pass++;
            else $error("FAIL %s ready: got %b want %b", tag, bus.req_ready, exp_ready);
        end
        @(posedge clock);
        if (drv_rst) begin
            for (int i = 0; i < N; i++) m_full[i] = 0;
            m_cdb  = '0;
            m_gidx = 0;
            m_ptr  = 0;
        end else begin
            if (g >= 0) begin
                m_cdb.valid   = 1'b1;
                m_cdb.rob_tag = m_tag[g];
                m_cdb.value   = m_value[g];
                m_gidx        = g;
                m_ptr         = (g + 1) % N;
                m_full[g]     = 0;
            end else begin
                m_cdb.valid = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (drv_sq[i]) m_full[i] = 0;
                if (drv_valid[i] && exp_ready[i]) begin
                    m_full[i]  = (drv_tag[i] != 0);
                    m_tag[i]   = drv_tag[i];
                    m_value[i] = drv_value[i];
                end
            end
        end
        #1;
        for (int i = 0; i < N; i++) exp_occ[i] = m_full[i];
        n_checks++;
        assert (bus.cdb_data === m_cdb) n_pass++;
        else $error("FAIL %s cdb_data: got %h want %h", tag, bus.cdb_data, m_cdb);
        n_checks++;
        assert (bus.grant_idx === 2'(m_gidx)) n_pass++;
        else $error("FAIL %s grant_idx: got %0d want %0d", tag, bus.grant_idx, m_gidx);
        n_checks++;
        assert (bus.buf_occupied === exp_occ) n_pass++;
        else $error("FAIL %s buf_occupied: got %b want %b", tag, bus.buf_occupied, exp_occ);
        if (bus.cdb_data.valid === 1'b1)
            $display("[%s] cdb port %0d tag %0d value %h", tag, bus.grant_idx,
                     bus.cdb_data.rob_tag, bus.cdb_data.value);
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        bus.req_valid   = '0;
        bus.squash_mask = '0;
        bus.req_rob_tag = '0;
        bus.req_value   = '0;
        for (int i = 0; i < N; i++) begin
            m_full[i] = 0; m_tag[i] = '0; m_value[i] = '0;
        end
        m_ptr = 0; m_cdb = '0; m_gidx = 0;
        @(negedge clock);

        // Reset with every port offering
        idle_drive();
        drv_rst = 1'b1;
        for (int i = 0; i < N; i++) offer(i, i + 1, 32'hA0 + i);
        step("reset0");
        step("reset1");
        idle_drive();
        step("post_reset");

        // Single port
        offer(CDB_LD, 3, 32'h55);
        step("single_offer");
        idle_drive();
        step("single_bcast");
        step("single_idle");

        // Round-robin from rr_ptr=0
        drv_rst = 1'b1;
        step("rr_reset");
        idle_drive();
        for (int i = 0; i < N; i++) offer(i, i + 1, 32'h100 + i);
        step("rr_load");
        idle_drive();
        for (int c = 0; c < 6; c++) step("rr_drain");

        // Back-to-back on port 0
        for (int t = 1; t <= 3; t++) begin
            idle_drive();
            offer(CDB_ALU, t, 32'h200 + t);
            step("b2b_offer");
        end
        idle_drive();
        step("b2b_drain");
        step("b2b_idle");

        // Squash port 3 while port 1 broadcasts
        offer(CDB_MULT, 2, 32'h302);
        offer(CDB_BR, 4, 32'h304);
        step("sq_load");
        idle_drive();
        drv_sq = 4'b1000;
        offer(CDB_BR, 9, 32'h309);
        step("sq_cycle");
        idle_drive();
        for (int c = 0; c < 4; c++) step("sq_drain");

        // Backpressure on port 1, then reset with buffers full
        drv_rst = 1'b1;
        step("bp_reset");
        idle_drive();
        offer(CDB_ALU, 5, 32'h405);
        offer(CDB_MULT, 1, 32'h401);
        step("bp_load");
        idle_drive();
        offer(CDB_MULT, 6, 32'h406);
        step("bp_held");
        idle_drive();
        for (int i = 0; i < N; i++) offer(i, 10 + i, 32'h500 + i);
        step("full_load");
        idle_drive();
        drv_rst = 1'b1;
        step("full_reset");
        idle_drive();
        for (int c = 0; c < 4; c++) step("full_after");

        // Tag 0 is acked and dropped
        offer(CDB_LD, 0, 32'h600);
        step("tag0_offer");
        idle_drive();
        step("tag0_idle");

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            idle_drive();
            drv_rst = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < N; i++) begin
                drv_valid[i] = ($urandom_range(0, 2) != 0);
                drv_tag[i]   = ROB_TAG_LEN'($urandom_range(0, 31));
                drv_value[i] = $urandom;
                drv_sq[i]    = ($urandom_range(0, 7) == 0);
            end
            step("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
